// File: rtl/ks_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: sizing functions,
// level-to-stage mapping and the two 1-bit prefix cells.
package ks_pkg;

    // Ceiling log2 for n >= 1 (number of prefix levels).
    function automatic int unsigned ks_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Register stages: the conditioning stage plus one per group of lps levels.
    function automatic int unsigned ks_num_stages(input int unsigned l, input int unsigned lps);
        return (l + lps - 1) / lps + 1;
    endfunction

    // Register stage whose input cone evaluates prefix level k.
    function automatic int unsigned ks_level_stage(input int unsigned k, input int unsigned lps);
        return k / lps + 1;
    endfunction

    // Generate/propagate cell, returns {g, p}.
    function automatic logic [1:0] ks_pg(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Black prefix cell, returns {g, p} of the combined span.
    function automatic logic [1:0] ks_black(input logic g_hi, input logic p_hi,
                                            input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

endpackage

// File: rtl/ks_adder_pipe_stage_reg.sv
// One pipeline slice: valid bit plus data register with load/hold control.
module ks_stage_reg #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Take the upstream beat (or bubble) when allowed to advance; data only moves
    // with a real beat so held results stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= valid_in;
            if (valid_in) data_q <= data_in;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ks_adder_pipe.sv
// Parametrised pipelined Kogge-Stone adder/subtractor with valid/ready flow.
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned L  = ks_clog2(WIDTH);
    localparam int unsigned D  = ks_num_stages(L, LPS);
    // Stage word: {b_msb, a_msb, c_eff, g, p_prefix, p_bitwise}
    localparam int unsigned DW = 3 * WIDTH + 3;
    localparam int unsigned PP = WIDTH;
    localparam int unsigned GO = 2 * WIDTH;
    localparam int unsigned CO = 3 * WIDTH;
    localparam int unsigned AM = 3 * WIDTH + 1;
    localparam int unsigned BM = 3 * WIDTH + 2;

    logic [DW-1:0] stage_q [D];
    logic [D-1:0]  stage_v;
    logic [D-1:0]  stage_vin;
    logic [D-1:0]  stage_load;

    assign stage_vin = {stage_v[D-2:0], in_valid};

    // Back-pressure chain: a stage advances when empty or when its successor advances.
    always_comb begin
        logic ld;
        ld = !stage_v[D-1] || out_ready;
        stage_load[D-1] = ld;
        for (int i = int'(D) - 2; i >= 0; i--) begin
            ld = !stage_v[i] || ld;
            stage_load[i] = ld;
        end
    end

    assign in_ready = stage_load[0];

    for (genvar s = 0; s < int'(D); s++) begin : g_stage
        logic [DW-1:0] d_in;

        if (s == 0) begin : g_cond
            // Operand conditioning and bitwise P/G with carry-in folded into bit 0.
            always_comb begin
                logic [WIDTH-1:0] b_eff, p, g;
                logic             c_eff;
                b_eff = sub ? ~b : b;
                c_eff = sub ? ~cin : cin;
                p = '0;
                g = '0;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    {g[i], p[i]} = ks_pg(a[i], b_eff[i]);
                end
                g[0] = g[0] | (p[0] & c_eff);
                d_in = {b_eff[WIDTH-1], a[WIDTH-1], c_eff, g, p, p};
            end
        end else begin : g_pref
            // Prefix levels mapped to this stage; low bits of each level pass through.
            always_comb begin
                logic [WIDTH-1:0] p, g, p_n, g_n;
                p   = stage_q[s-1][PP +: WIDTH];
                g   = stage_q[s-1][GO +: WIDTH];
                p_n = '0;
                g_n = '0;
                for (int unsigned k = 0; k < L; k++) begin
                    if (ks_level_stage(k, LPS) == s) begin
                        p_n = p;
                        g_n = g;
                        for (int unsigned i = (1 << k); i < WIDTH; i++) begin
                            {g_n[i], p_n[i]} = ks_black(g[i], p[i],
                                                        g[i - (1 << k)], p[i - (1 << k)]);
                        end
                        p = p_n;
                        g = g_n;
                    end
                end
                d_in = stage_q[s-1];
                d_in[PP +: WIDTH] = p;
                d_in[GO +: WIDTH] = g;
            end
        end

        ks_stage_reg #(
            .DW(DW)
        ) u_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (stage_load[s]),
            .valid_in(stage_vin[s]),
            .data_in (d_in),
            .valid   (stage_v[s]),
            .data    (stage_q[s])
        );
    end

    logic [DW-1:0]    last;
    logic [WIDTH-1:0] gpref;
    logic             unused_ppref;

    assign last         = stage_q[D-1];
    assign gpref        = last[GO +: WIDTH];
    assign unused_ppref = ^last[PP +: WIDTH];

    // Final sum and flags straight off the last register.
    always_comb begin
        sum       = last[WIDTH-1:0] ^ {gpref[WIDTH-2:0], last[CO]};
        cout      = gpref[WIDTH-1];
        ovf       = (last[AM] == last[BM]) && (sum[WIDTH-1] != last[AM]);
        out_valid = stage_v[D-1];
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed and streaming bench for ks_adder_pipe at WIDTH=32/LPS=2 and WIDTH=6/LPS=1.
module tb_ks_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;
    logic        in_valid6, in_ready6, cin6, sub6, out_valid6, out_ready6, cout6, ovf6;
    logic [5:0]  a6, b6, sum6;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ks_adder_pipe #(.WIDTH(32), .LPS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    ks_adder_pipe #(.WIDTH(6), .LPS(1)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .a(a6), .b(b6), .cin(cin6), .sub(sub6), .out_valid(out_valid6),
        .out_ready(out_ready6), .sum(sum6), .cout(cout6), .ovf(ovf6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference returning {ovf, cout, sum} for a w-bit adder.
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        longint ux, uy, ur, sx, sy, sr, lim;
        logic   co, ov;
        ux  = longint'({32'b0, x});
        uy  = longint'({32'b0, y});
        lim = longint'(1) << (w - 1);
        sx  = x[w-1] ? ux - 2 * lim : ux;
        sy  = y[w-1] ? uy - 2 * lim : uy;
        if (s) begin
            ur = ux - uy - longint'(c);
            co = (ur >= 0);
            sr = sx - sy - longint'(c);
        end else begin
            ur = ux + uy + longint'(c);
            co = ((ur >> w) & 1) != 0;
            sr = sx + sy + longint'(c);
        end
        ov = (sr >= lim) || (sr < -lim);
        return {ov, co, 32'(ur & (2 * lim - 1))};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [33:0] exp;
    } vec_t;

    vec_t vecs [7] = '{
        '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 34'h1_0000_0000},
        '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 34'h0_FFFF_FFFE},
        '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 34'h3_7FFF_FFFF},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 34'h2_8000_0000},
        '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 34'h0_FFFF_FFFD},
        '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 34'h1_0000_0002},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 34'h3_0000_0000}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [33:0] expq [$];
        logic [33:0] exp_v, held;
        logic [31:0] sa [20];
        logic [31:0] sb [20];
        logic        sc [20];
        logic        ss [20];
        logic        held_valid;
        int          lat, sent, got, seen, first, lastc, stalls;

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid6 = 1'b0; a6 = '0; b6 = '0; cin6 = 1'b0; sub6 = 1'b0; out_ready6 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({ovf, cout, sum}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, with latency measurement.
        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            in_valid = 1'b0;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("dir%0d_result", i), 64'({ovf, cout, sum}), 64'(vecs[i].exp));
            @(negedge clk);
        end

        // Stream of 20 random beats with a consumer stall in cycles 5..14.
        foreach (sa[i]) begin
            sa[i] = $urandom; sb[i] = $urandom;
            sc[i] = 1'($urandom_range(1)); ss[i] = 1'($urandom_range(1));
        end
        sent = 0; got = 0; held_valid = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 14);
            in_valid  = (sent < 20);
            if (sent < 20) begin
                a = sa[sent]; b = sb[sent]; cin = sc[sent]; sub = ss[sent];
            end
            #1;
            if (held_valid)
                check("stall_stable", 64'({out_valid, ovf, cout, sum}), 64'({1'b1, held}));
            if (cyc == 14) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_occupancy", 64'(sent - got), 64'd4);
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(32, a, b, cin, sub));
                sent++;
            end
            held_valid = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    exp_v = (expq.size() > 0) ? expq.pop_front() : 34'h3_FFFF_FFFF;
                    check($sformatf("stream%0d", got), 64'({ovf, cout, sum}), 64'(exp_v));
                    got++;
                end else begin
                    held_valid = 1'b1;
                    held = {ovf, cout, sum};
                end
            end
        end
        check("stream_count", 64'(got), 64'd20);

        // Reset with three beats in flight, first one already at the output.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 32'h1234_5678 + 32'(i); b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_result", 64'({ovf, cout, sum}), 64'(model(32, 32'h1234_5678, 32'h1, 1'b0, 1'b0)));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outputs", 64'({ovf, cout, sum}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_no_stale", 64'(seen), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // WIDTH=6, LPS=1: 10k random beats at full rate against the model.
        expq.delete();
        sent = 0; got = 0; first = -1; lastc = -1; stalls = 0;
        for (int cyc = 0; cyc < 10200 && got < 10000; cyc++) begin
            @(negedge clk);
            out_ready6 = 1'b1;
            if (sent < 10000) begin
                in_valid6 = 1'b1;
                a6 = 6'($urandom); b6 = 6'($urandom);
                cin6 = 1'($urandom_range(1)); sub6 = 1'($urandom_range(1));
            end else begin
                in_valid6 = 1'b0;
            end
            #1;
            if (in_valid6 && !in_ready6) stalls++;
            if (in_valid6 && in_ready6) begin
                expq.push_back(model(6, {26'b0, a6}, {26'b0, b6}, cin6, sub6));
                sent++;
            end
            if (out_valid6) begin
                exp_v = (expq.size() > 0) ? expq.pop_front() : 34'h3_FFFF_FFFF;
                check("w6_vec", 64'({ovf6, cout6, 26'b0, sum6}), 64'(exp_v));
                if (first < 0) first = cyc;
                lastc = cyc;
                got++;
            end
        end
        check("w6_count", 64'(got), 64'd10000);
        check("w6_throughput", 64'(lastc - first + 1), 64'd10000);
        check("w6_ready_stalls", 64'(stalls), 64'd0);
        in_valid6 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor; next generation of the fixed-width 6/14/30-bit prefix adders used in the Dadda multiplier final stage. Adds arbitrary width, carry-in, subtract mode, carry/overflow flags, and configurable pipeline registers between prefix levels with valid/ready back-pressure. Sits at the multiplier's final carry-propagate stage and serves as a general-purpose ALU adder.

## Interface
- WIDTH, 32: operand/sum width, >= 2.
- LPS, 2: prefix levels per pipeline stage, >= 1.
- Derived L = clog2(WIDTH) prefix levels; D = ceil(L/LPS) + 1 register stages.

- clk  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  1: A - B - cin; 0: A + B + cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, mod 2^WIDTH
- cout  out  1  carry-out; in sub mode 1 = no borrow
- ovf  out  1  two's-complement signed overflow

## Operation
- Beat transfers in when in_valid && in_ready; out when out_valid && out_ready.
- Operand conditioning: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin.
- Stage 0: bitwise P = a ^ b_eff, G = a & b_eff; fold carry-in into bit 0: G0 = G[0] | (P[0] & c_eff). Register P, G, c_eff, a[MSB], b_eff[MSB].
- Prefix levels k = 0..L-1: span 2^k; black cell G = G_hi | (P_hi & G_lo), P = P_hi & P_lo; bits < 2^k pass through. Register after every LPS levels and after the last level.
- Final: sum = P ^ {Gpref[WIDTH-2:0], c_eff}; cout = Gpref[WIDTH-1]; ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). Computed combinationally from last stage register.
- Handshake: each stage holds a valid bit; stage i loads when empty or stage i+1 loads/drains this cycle. in_ready = !v0 || stage-0 advances. Full throughput 1 beat/cycle with out_ready held high.
- No drop, no duplication, strict in-order delivery. Output data stable while out_valid && !out_ready.
- Reset: all valid bits 0, all data registers 0 → out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 from first cycle after rst_n rises. Assertion mid-operation discards all in-flight beats immediately.

## Timing
- Latency D cycles from accepting edge to out_valid (no stalls). WIDTH=32, LPS=2: L=5, D=4. WIDTH=6, LPS=1: L=3, D=4.
- in_ready depends combinationally on out_ready through the valid chain; no other input-to-output combinational paths.
- Simultaneous in and out transfer on a full pipe: allowed, occupancy unchanged.
- Pipe capacity D beats; with out_ready=0, in_ready drops after D accepts.

## Structure
- Package ks_pkg: clog2 function, stage-count function ceil(L/LPS)+1, level-to-stage mapping.
- Reuse existing PG and blackCell cells for generate/prefix logic.
- One sub-module ks_stage_reg: valid bit + data register slice with load/hold logic, instantiated once per stage.

## Test plan
- WIDTH=32, LPS=2: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1, cout=0.
- Stream 20 random beats, out_ready low cycles 5-14 -> in_ready low after 4 held beats, all 20 results correct, in order, output stable while stalled.
- Assert rst_n mid-stream with 3 beats in flight -> out_valid=0 and all outputs 0 immediately; no stale beat emerges after release.
- WIDTH=6, LPS=1, 10k random vectors vs reference model, both modes -> zero mismatches, throughput 1 beat/cycle.
